// File: rtl/operand_stage_buffer.sv
// Operand staging buffer: collects up to DEPTH operands and releases them on an op.
// Define OPSTAGE_PC_GATE_EN to act only once per program-counter value.
module operand_stage_buffer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 3,
  parameter int PC_W    = 12,
  parameter int MODE    = 0,
  parameter int CONSUME = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         put_en,
  input  logic                         op_en,
  input  logic [WIDTH-1:0]             value,
  input  logic [PC_W-1:0]              prog_ctr,
  input  logic                         err_clr,
  output logic [DEPTH*WIDTH-1:0]       slot_data,
  output logic [DEPTH-1:0]             slot_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow_err,
  output logic                         conflict_err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [WIDTH-1:0] slot_n [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_n, take;
  logic             ovf_q, conf_q, ovf_set, conf_set;
  logic             accept;

`ifdef OPSTAGE_PC_GATE_EN
  logic            pc_seen;
  logic [PC_W-1:0] last_pc;

  assign accept = !pc_seen || (prog_ctr != last_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_seen <= 1'b0;
      last_pc <= '0;
    end else if (accept) begin
      pc_seen <= 1'b1;
      last_pc <= prog_ctr;
    end
  end
`else
  logic unused_pc;

  assign accept    = 1'b1;
  assign unused_pc = ^prog_ctr;
`endif

  assign take = (cnt_q < CW'(CONSUME)) ? cnt_q : CW'(CONSUME);

  always_comb begin
    slot_n   = slot_q;
    cnt_n    = cnt_q;
    ovf_set  = 1'b0;
    conf_set = 1'b0;
    if (accept) begin
      if (put_en && op_en) begin
        conf_set = 1'b1;
      end else if (put_en) begin
        if (cnt_q == CW'(DEPTH)) begin
          ovf_set = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++)
            if (CW'(i) == cnt_q) slot_n[i] = value;
          cnt_n = cnt_q + 1'b1;
        end
      end else if (op_en) begin
        if (MODE == 0) begin
          cnt_n = '0;
        end else begin
          // Shift survivors down by take; slots past the new count keep stale data
          for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
              if (j == i + int'(take)) slot_n[i] = slot_q[j];
          cnt_n = cnt_q - take;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      conf_q <= 1'b0;
    end else begin
      slot_q <= slot_n;
      cnt_q  <= cnt_n;
      ovf_q  <= ovf_set  | (ovf_q  & ~err_clr);
      conf_q <= conf_set | (conf_q & ~err_clr);
    end
  end

  always_comb begin
    slot_data  = '0;
    slot_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_data[i*WIDTH +: WIDTH] = slot_q[i];
      slot_valid[i]               = (CW'(i) < cnt_q);
    end
  end

  assign count        = cnt_q;
  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign overflow_err = ovf_q;
  assign conflict_err = conf_q;

endmodule

// File: tb/tb_operand_stage_buffer.sv
// Scoreboard bench: one DUT per release mode, both driven identically and checked
// against queue-based reference models.
module tb_operand_stage_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int PC_W  = 12;
  localparam int DW    = DEPTH*WIDTH;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            put_en = 1'b0, op_en = 1'b0, err_clr = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic [PC_W-1:0]  prog_ctr = '0;

  logic [DW-1:0]    data0, data1;
  logic [DEPTH-1:0] valid0, valid1;
  logic [1:0]       count0, count1;
  logic             full0, full1, empty0, empty1, ovf0, ovf1, conf0, conf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W), .MODE(0), .CONSUME(2)) dut0 (
    .clk(clk), .reset(reset), .put_en(put_en), .op_en(op_en), .value(value),
    .prog_ctr(prog_ctr), .err_clr(err_clr), .slot_data(data0), .slot_valid(valid0),
    .count(count0), .full(full0), .empty(empty0), .overflow_err(ovf0), .conflict_err(conf0));

  operand_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W), .MODE(1), .CONSUME(2)) dut1 (
    .clk(clk), .reset(reset), .put_en(put_en), .op_en(op_en), .value(value),
    .prog_ctr(prog_ctr), .err_clr(err_clr), .slot_data(data1), .slot_valid(valid1),
    .count(count1), .full(full1), .empty(empty1), .overflow_err(ovf1), .conflict_err(conf1));

  typedef struct {
    int          cnt;
    logic [DW-1:0] data;
    logic        ovf;
    logic        conf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  // Reference state: operand queues, plus the raw slot contents that mode 0 leaves behind
  logic [WIDTH-1:0] ops0[$];
  logic [WIDTH-1:0] ops1[$];
  logic [WIDTH-1:0] stale0 [DEPTH];
  bit               m_ovf0, m_conf0, m_ovf1, m_conf1;
  bit               have_pc;
  logic [PC_W-1:0]  seen_pc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compareDut(input string tag, input exp_t e, input bit all_data,
                            input logic [DW-1:0] d, input logic [DEPTH-1:0] v,
                            input logic [1:0] c, input logic f, input logic em,
                            input logic o, input logic cf);
    logic [DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (all_data || i < e.cnt) mask[i*WIDTH +: WIDTH] = '1;
    checkOutput({tag, ".count"}, 32'(c), 32'(e.cnt));
    checkOutput({tag, ".slot_valid"}, 32'(v), 32'((1 << e.cnt) - 1));
    checkOutput({tag, ".full"}, 32'(f), 32'(e.cnt == DEPTH));
    checkOutput({tag, ".empty"}, 32'(em), 32'(e.cnt == 0));
    checkOutput({tag, ".slot_data"}, 32'(d & mask), 32'(e.data & mask));
    checkOutput({tag, ".overflow_err"}, 32'(o), 32'(e.ovf));
    checkOutput({tag, ".conflict_err"}, 32'(cf), 32'(e.conf));
  endtask

  // Drive at negedge, advance the model at the sampling posedge, queue the expectation
  task automatic applyStimulus(input bit rst, input bit put, input bit op,
                               input logic [WIDTH-1:0] val, input logic [PC_W-1:0] pc,
                               input bit clr);
    bit   acc, o0, o1, c0, c1;
    int   n;
    exp_t x0, x1;
    @(negedge clk);
    reset = rst; put_en = put; op_en = op; value = val; prog_ctr = pc; err_clr = clr;
    @(posedge clk);
    if (rst) begin
      ops0.delete(); ops1.delete();
      for (int i = 0; i < DEPTH; i++) stale0[i] = '0;
      m_ovf0 = 0; m_conf0 = 0; m_ovf1 = 0; m_conf1 = 0;
      have_pc = 0; seen_pc = '0;
    end else begin
`ifdef OPSTAGE_PC_GATE_EN
      acc = !have_pc || (pc != seen_pc);
      if (acc) begin have_pc = 1; seen_pc = pc; end
`else
      acc = 1;
`endif
      o0 = acc && put && !op && ops0.size() == DEPTH;
      o1 = acc && put && !op && ops1.size() == DEPTH;
      c0 = acc && put && op;
      c1 = c0;
      if (acc && put && !op) begin
        if (ops0.size() < DEPTH) begin stale0[ops0.size()] = val; ops0.push_back(val); end
        if (ops1.size() < DEPTH) ops1.push_back(val);
      end
      if (acc && op && !put) begin
        ops0.delete();
        n = (ops1.size() < 2) ? ops1.size() : 2;
        repeat (n) void'(ops1.pop_front());
      end
      m_ovf0  = o0 || (m_ovf0  && !clr);
      m_conf0 = c0 || (m_conf0 && !clr);
      m_ovf1  = o1 || (m_ovf1  && !clr);
      m_conf1 = c1 || (m_conf1 && !clr);
    end
    x0.cnt = ops0.size(); x0.ovf = m_ovf0; x0.conf = m_conf0;
    for (int i = 0; i < DEPTH; i++) x0.data[i*WIDTH +: WIDTH] = stale0[i];
    x1.cnt = ops1.size(); x1.ovf = m_ovf1; x1.conf = m_conf1; x1.data = '0;
    for (int i = 0; i < ops1.size(); i++) x1.data[i*WIDTH +: WIDTH] = ops1[i];
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        compareDut("mode0", e0, 1'b1, data0, valid0, count0, full0, empty0, ovf0, conf0);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        compareDut("mode1", e1, 1'b0, data1, valid1, count1, full1, empty1, ovf1, conf1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PC_W-1:0] pc;
    bit rs, pu, op, cl;

    applyStimulus(1, 0, 0, 8'd0, 12'd0, 0);
    applyStimulus(0, 1, 0, 8'd5, 12'd1, 0);
    applyStimulus(0, 1, 0, 8'd9, 12'd2, 0);
    applyStimulus(0, 1, 0, 8'd12, 12'd3, 0);
    applyStimulus(0, 1, 0, 8'd77, 12'd4, 0);
    applyStimulus(0, 0, 0, 8'd0, 12'd5, 1);
    applyStimulus(0, 0, 1, 8'd0, 12'd6, 0);
    applyStimulus(0, 0, 1, 8'd0, 12'd7, 0);

    applyStimulus(1, 0, 0, 8'd0, 12'd7, 0);
    repeat (4) applyStimulus(0, 1, 0, 8'd33, 12'd7, 0);

    applyStimulus(1, 0, 0, 8'd0, 12'd0, 0);
    applyStimulus(0, 1, 0, 8'd5, 12'd1, 0);
    applyStimulus(0, 1, 0, 8'd9, 12'd2, 0);
    applyStimulus(0, 1, 0, 8'd12, 12'd3, 0);
    applyStimulus(0, 1, 1, 8'd50, 12'd8, 1);
    applyStimulus(0, 0, 0, 8'd0, 12'd9, 1);

    applyStimulus(1, 0, 0, 8'd0, 12'd0, 0);
    applyStimulus(0, 1, 0, 8'd1, 12'd10, 0);
    applyStimulus(0, 1, 0, 8'd2, 12'd11, 0);
    applyStimulus(1, 1, 0, 8'd3, 12'd11, 0);
    applyStimulus(0, 1, 0, 8'd44, 12'd11, 0);

    pc = 12'd11;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0) pc = 12'($urandom_range(0, 4095));
      rs = ($urandom_range(0, 39) == 0);
      pu = ($urandom_range(0, 1) == 0);
      op = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 9) == 0);
      applyStimulus(rs, pu, op, 8'($urandom_range(0, 255)), pc, cl);
    end

    repeat (2) @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_stage_buffer.md
Name: operand_stage_buffer

Overview:
- Parametrised successor to the three-slot operand accumulator: stages up to DEPTH operands of WIDTH bits for a following execute op.
- Operands are put one per instruction; an op instruction releases them.
- Gated by program-counter change, so a multi-cycle instruction acts once.
- Adds reset, a configurable release mode, full/empty/count status and sticky error flags.

Parameters:
- WIDTH, 8, operand width in bits
- DEPTH, 3, number of operand slots (>=2)
- PC_W, 12, program counter width
- MODE, 0, op release mode: 0 = clear all slots, 1 = consume CONSUME slots from head and shift the rest down
- CONSUME, 2, slots removed per op when MODE=1 (1..DEPTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- put_en  in  1  request to store value in the next free slot
- op_en  in  1  request to release operands
- value  in  WIDTH  operand to store
- prog_ctr  in  PC_W  current program counter, used for once-per-instruction gating
- err_clr  in  1  clears sticky error flags
- slot_data  out  DEPTH*WIDTH  slot i at bits [i*WIDTH +: WIDTH]; slot 0 is the oldest
- slot_valid  out  DEPTH  per-slot valid; always packed low (thermometer)
- count  out  $clog2(DEPTH+1)  number of valid slots
- full  out  1  count==DEPTH, combinational from state
- empty  out  1  count==0, combinational from state
- overflow_err  out  1  sticky: put attempted while full
- conflict_err  out  1  sticky: put_en and op_en both high on an accepted cycle

Behaviour:
- Reset (sampled at posedge while reset=1): slot_data=0, slot_valid=0, count=0, overflow_err=0, conflict_err=0, pc_seen=0, last_pc=0. Reset overrides all other inputs.
- Accepted cycle:
  - Occurs when !pc_seen or prog_ctr != last_pc.
  - On every accepted cycle, last_pc<=prog_ctr and pc_seen<=1, whatever put_en/op_en are.
  - Non-accepted cycles change no slot state or error flag; err_clr still applies.
- Latency: 1 cycle. Effects are visible on outputs after the edge that samples the request. No same-cycle bypass.
- Accepted put_en=1, op_en=0:
  - Not full: slot[count]<=value, slot_valid[count]<=1, count+1.
  - Full: value dropped, slots unchanged, overflow_err<=1.
- Accepted op_en=1, put_en=0:
  - MODE=0: all slot_valid<=0, count<=0. slot_data holds stale values.
  - MODE=1: n=min(count,CONSUME). Slot i<=slot i+n for i<count-n. count<=count-n. Valid bits re-packed low. Op on empty: no change, no error.
- Accepted, both high: no slot change, conflict_err<=1.
- Accepted, neither high: no slot change.
- err_clr=1 clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- Data width is exact WIDTH; no arithmetic on operands.
- count never exceeds DEPTH and never underflows.
- Reset mid-sequence clears pc_seen, so the same prog_ctr is accepted again on the first post-reset cycle.

Optional Feature:
- Macro: OPSTAGE_PC_GATE_EN
- Defined: PC-change gating as described above.
- Undefined:
  - Every non-reset cycle is accepted.
  - last_pc and pc_seen are not implemented.
  - A put_en held for k cycles stores k operands, subject to full/overflow rules.

Test Plan:
- Reset, then puts of 5, 9, 12 at prog_ctr 1, 2, 3 -> slot0=5, slot1=9, slot2=12, slot_valid=3'b111, count=3, full=1.
- put_en held 4 cycles at prog_ctr=7 with value=33 (gate enabled) -> exactly one store: count=1, slot0=33; with the macro undefined, count=3 and overflow_err=1 after cycle 4.
- Full buffer (DEPTH=3), put of 77 at new PC -> overflow_err=1, slots unchanged. err_clr pulse -> overflow_err=0.
- MODE=0, count=3, op at new PC -> slot_valid=0, count=0, empty=1. MODE=1, CONSUME=2, slots 5/9/12, op -> slot0=12, count=1, slot_valid=3'b001.
- put_en and op_en both high at new PC -> conflict_err=1, count unchanged. Same cycle with err_clr=1 -> conflict_err still 1.
- count=2, reset asserted for one cycle with same prog_ctr held and put_en=1 -> count=0 after reset, then value stored on next cycle (count=1).
